// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: sequencing FSM for the multi-cycle RV32I core.
// Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB and handles
// the instruction and data memory ready handshakes with a bounded wait.
// Enables are decoded from the state register plus current inputs and are
// forced low while rst is high, so nothing fires during or after an abort.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_wr,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_wr,
    output logic             pc_wr,
    output logic             pc_src,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    // Wait counter only has to reach TIMEOUT; the trap fires instead of wrapping.
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic imem_req_s, ir_wr_s, dmem_req_s, dmem_we_s, rf_wr_s, pc_wr_s, pc_src_s;
    logic op_alu_s, op_load_s, op_store_s, op_branch_s, op_jump_s, op_legal_s;
    logic timed_out_s;

    // Opcode class helpers
    function automatic logic is_alu(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: is_alu = 1'b1;
            default:                                        is_alu = 1'b0;
        endcase
    endfunction

    function automatic logic is_jump(input logic [6:0] op);
        case (op)
            7'b1101111, 7'b1100111: is_jump = 1'b1;
            default:                is_jump = 1'b0;
        endcase
    endfunction

    assign op_alu_s    = is_alu(opcode);
    assign op_load_s   = (opcode == 7'b0000011);
    assign op_store_s  = (opcode == 7'b0100011);
    assign op_branch_s = (opcode == 7'b1100011);
    assign op_jump_s   = is_jump(opcode);
    assign op_legal_s  = op_alu_s | op_load_s | op_store_s | op_branch_s | op_jump_s;

    // Ready in the last allowed wait cycle still wins over the trap.
    assign timed_out_s = (wait_q == WAIT_MAX);

    // Next-state, wait-counter and enable decode for the sequencing FSM
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        imem_req_s = 1'b0;
        ir_wr_s    = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        rf_wr_s    = 1'b0;
        pc_wr_s    = 1'b0;
        pc_src_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_wr_s = 1'b1;
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else if (timed_out_s) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                wait_d = '0;
                if (op_legal_s) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                wait_d = '0;
                if (op_load_s || op_store_s) begin
                    state_d = S_MEM;
                end else if (op_alu_s || op_jump_s) begin
                    state_d = S_WB;
                end else if (op_branch_s) begin
                    pc_wr_s  = 1'b1;
                    pc_src_s = br_taken;
                    state_d  = S_FETCH;
                end else begin
                    // Opcode changed under us after DECODE: treat as illegal.
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = op_store_s;
                if (dmem_ready) begin
                    wait_d = '0;
                    if (op_store_s) begin
                        pc_wr_s  = 1'b1;
                        pc_src_s = 1'b0;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out_s) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                wait_d   = '0;
                rf_wr_s  = 1'b1;
                pc_wr_s  = 1'b1;
                pc_src_s = op_jump_s;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                wait_d  = '0;
                state_d = S_TRAP;
            end
            default: begin
                wait_d  = '0;
                state_d = S_FETCH;
            end
        endcase
    end

    // Retired-instruction count advances on every PC update and wraps naturally.
    assign retired_d = retired_q + CNT_W'(pc_wr_s);

    // State, wait counter, sticky flags and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req = imem_req_s & ~rst;
    assign ir_wr    = ir_wr_s    & ~rst;
    assign dmem_req = dmem_req_s & ~rst;
    assign dmem_we  = dmem_we_s  & ~rst;
    assign rf_wr    = rf_wr_s    & ~rst;
    assign pc_wr    = pc_wr_s    & ~rst;
    assign pc_src   = pc_src_s   & ~rst;
    assign state    = state_q;
    assign illegal  = illegal_q;
    assign bus_err  = bus_err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
// Expected values are per-cycle {state, imem_req, ir_wr, dmem_req, dmem_we,
// rf_wr, pc_wr, pc_src} words worked out by hand.
module tb_multicycle_ctrl;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       opcode = 7'd0;
    logic             br_taken = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req, ir_wr, dmem_req, dmem_we, rf_wr, pc_wr, pc_src;
    logic [2:0]       state;
    logic             illegal, bus_err;
    logic [CNT_W-1:0] retired;
    logic [6:0]       outs_s;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_ctrl #(.TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_wr(ir_wr), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_wr(rf_wr), .pc_wr(pc_wr), .pc_src(pc_src), .state(state),
        .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    assign outs_s = {imem_req, ir_wr, dmem_req, dmem_we, rf_wr, pc_wr, pc_src};

    // Pulse reset for one cycle; returns at the falling edge where rst drops.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        opcode = 7'b0110011; imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b1;
        #1;
        n_cmp++;
        if ({state, outs_s} !== 10'd0 || illegal !== 1'b0 || bus_err !== 1'b0 || retired !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hold: state=%0d outs=%b ill=%b berr=%b ret=%0d, required all zero",
                     state, outs_s, illegal, bus_err, retired);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({state, outs_s} !== 10'd0 || retired !== 32'd0) begin
            n_err++;
            $display("FAIL reset_edge: state=%0d outs=%b ret=%0d, required all zero", state, outs_s, retired);
        end
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({state, outs_s} !== 10'b000_1000000) begin
            n_err++;
            $display("FAIL first_fetch: state=%0d outs=%b, required state=0 outs=1000000", state, outs_s);
        end
    endtask

    task automatic test_alu();
        logic [9:0] exp_v [5];
        int         exp_r [5];
        exp_v = '{10'b000_1100000, 10'b001_0000000, 10'b010_0000000, 10'b100_0000110, 10'b000_1100000};
        exp_r = '{0, 0, 0, 0, 1};
        opcode = 7'b0110011; imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({state, outs_s} !== exp_v[i] || retired !== 32'(exp_r[i])) begin
                n_err++;
                $display("FAIL alu cyc%0d: state=%0d outs=%b ret=%0d, required state=%0d outs=%b ret=%0d",
                         i, state, outs_s, retired, exp_v[i][9:7], exp_v[i][6:0], exp_r[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        logic [9:0] exp_v [9];
        int         exp_r [9];
        exp_v = '{10'b000_1100000, 10'b001_0000000, 10'b010_0000000,
                  10'b011_0010000, 10'b011_0010000, 10'b011_0010000, 10'b011_0010000,
                  10'b100_0000110, 10'b000_1100000};
        exp_r = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        opcode = 7'b0000011; imem_ready = 1'b1; dmem_ready = 1'b0; br_taken = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            dmem_ready = (i == 6);
            #1;
            n_cmp++;
            if ({state, outs_s} !== exp_v[i] || retired !== 32'(exp_r[i])) begin
                n_err++;
                $display("FAIL load cyc%0d: state=%0d outs=%b ret=%0d, required state=%0d outs=%b ret=%0d",
                         i, state, outs_s, retired, exp_v[i][9:7], exp_v[i][6:0], exp_r[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [9:0] exp_v [7];
        int         exp_r [7];
        exp_v = '{10'b000_1100000, 10'b001_0000000, 10'b010_0000011,
                  10'b000_1100000, 10'b001_0000000, 10'b010_0000010, 10'b000_1100000};
        exp_r = '{0, 0, 0, 1, 1, 1, 2};
        opcode = 7'b1100011; imem_ready = 1'b1; dmem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            br_taken = (i < 3);
            #1;
            n_cmp++;
            if ({state, outs_s} !== exp_v[i] || retired !== 32'(exp_r[i])) begin
                n_err++;
                $display("FAIL branch cyc%0d: state=%0d outs=%b ret=%0d, required state=%0d outs=%b ret=%0d",
                         i, state, outs_s, retired, exp_v[i][9:7], exp_v[i][6:0], exp_r[i]);
            end
            @(negedge clk);
        end
    endtask

    // JUMP with two instruction-memory wait states before the fetch completes.
    task automatic test_jump_wait();
        logic [9:0] exp_v [7];
        int         exp_r [7];
        exp_v = '{10'b000_1000000, 10'b000_1000000, 10'b000_1100000, 10'b001_0000000,
                  10'b010_0000000, 10'b100_0000111, 10'b000_1100000};
        exp_r = '{0, 0, 0, 0, 0, 0, 1};
        opcode = 7'b1101111; dmem_ready = 1'b1; br_taken = 1'b0; imem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            imem_ready = (i >= 2);
            #1;
            n_cmp++;
            if ({state, outs_s} !== exp_v[i] || retired !== 32'(exp_r[i])) begin
                n_err++;
                $display("FAIL jump cyc%0d: state=%0d outs=%b ret=%0d, required state=%0d outs=%b ret=%0d",
                         i, state, outs_s, retired, exp_v[i][9:7], exp_v[i][6:0], exp_r[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [9:0] e;
        logic       e_ill;
        opcode = 7'b1111111; imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b1;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            e     = (i == 0) ? 10'b000_1100000 : (i == 1) ? 10'b001_0000000 : 10'b101_0000000;
            e_ill = (i >= 2);
            #1;
            n_cmp++;
            if ({state, outs_s} !== e || illegal !== e_ill || retired !== 32'd0) begin
                n_err++;
                $display("FAIL illegal cyc%0d: state=%0d outs=%b ill=%b ret=%0d, required state=%0d outs=%b ill=%b ret=0",
                         i, state, outs_s, illegal, retired, e[9:7], e[6:0], e_ill);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (illegal !== 1'b0 || state !== 3'd0) begin
            n_err++;
            $display("FAIL illegal_clear: ill=%b state=%0d, required ill=0 state=0", illegal, state);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({state, outs_s} !== 10'b000_1100000 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_restart: state=%0d outs=%b ill=%b, required state=0 outs=1100000 ill=0",
                     state, outs_s, illegal);
        end
    endtask

    task automatic test_fetch_timeout();
        logic [9:0] e;
        logic       e_be;
        opcode = 7'b0110011; imem_ready = 1'b0; dmem_ready = 1'b1; br_taken = 1'b0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            e    = (i < 16) ? 10'b000_1000000 : 10'b101_0000000;
            e_be = (i >= 16);
            #1;
            n_cmp++;
            if ({state, outs_s} !== e || bus_err !== e_be) begin
                n_err++;
                $display("FAIL fetch_to cyc%0d: state=%0d outs=%b berr=%b, required state=%0d outs=%b berr=%b",
                         i, state, outs_s, bus_err, e[9:7], e[6:0], e_be);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_timeout();
        logic [9:0] e;
        logic       e_be;
        int         e_r;
        // Data memory never answers: 16 MEM cycles then TRAP.
        opcode = 7'b0100011; imem_ready = 1'b1; dmem_ready = 1'b0; br_taken = 1'b0;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            if (i == 0)      e = 10'b000_1100000;
            else if (i == 1) e = 10'b001_0000000;
            else if (i == 2) e = 10'b010_0000000;
            else if (i < 19) e = 10'b011_0011000;
            else             e = 10'b101_0000000;
            e_be = (i >= 19);
            #1;
            n_cmp++;
            if ({state, outs_s} !== e || bus_err !== e_be || retired !== 32'd0) begin
                n_err++;
                $display("FAIL store_to cyc%0d: state=%0d outs=%b berr=%b ret=%0d, required state=%0d outs=%b berr=%b ret=0",
                         i, state, outs_s, bus_err, retired, e[9:7], e[6:0], e_be);
            end
            @(negedge clk);
        end
        // Two fetch waits first (counter must restart in MEM), then ready on the 16th MEM cycle.
        imem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            imem_ready = (i >= 2);
            dmem_ready = (i == 20);
            if (i < 2)        e = 10'b000_1000000;
            else if (i == 2)  e = 10'b000_1100000;
            else if (i == 3)  e = 10'b001_0000000;
            else if (i == 4)  e = 10'b010_0000000;
            else if (i < 20)  e = 10'b011_0011000;
            else if (i == 20) e = 10'b011_0011010;
            else              e = 10'b000_1100000;
            e_r = (i == 21) ? 1 : 0;
            #1;
            n_cmp++;
            if ({state, outs_s} !== e || bus_err !== 1'b0 || retired !== 32'(e_r)) begin
                n_err++;
                $display("FAIL store_late cyc%0d: state=%0d outs=%b berr=%b ret=%0d, required state=%0d outs=%b berr=0 ret=%0d",
                         i, state, outs_s, bus_err, retired, e[9:7], e[6:0], e_r);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        opcode = 7'b0100011; imem_ready = 1'b1; dmem_ready = 1'b0; br_taken = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({state, outs_s} !== 10'b011_0011000) begin
            n_err++;
            $display("FAIL abort_pre: state=%0d outs=%b, required state=3 outs=0011000", state, outs_s);
        end
        #2;
        rst = 1'b1;
        dmem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({state, outs_s} !== 10'd0 || retired !== 32'd0) begin
            n_err++;
            $display("FAIL abort_now: state=%0d outs=%b ret=%0d, required all zero", state, outs_s, retired);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({state, outs_s} !== 10'd0 || retired !== 32'd0) begin
            n_err++;
            $display("FAIL abort_hold: state=%0d outs=%b ret=%0d, required all zero", state, outs_s, retired);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({state, outs_s} !== 10'b000_1100000 || retired !== 32'd0) begin
            n_err++;
            $display("FAIL abort_release: state=%0d outs=%b ret=%0d, required state=0 outs=1100000 ret=0",
                     state, outs_s, retired);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_jump_wait();
        test_illegal();
        test_fetch_timeout();
        test_store_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
